// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter with ACK check and watchdog
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       CLK_G,
    input  logic       reset_G,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_err,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_drv_low,
    output logic       ps2data_drv_low
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_BITS    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    logic [2:0]    state;
    logic [9:0]    frame;
    logic [3:0]    bit_idx;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] wd_cnt;
    logic          clk_s1, clk_s2, clk_prev;
    logic          data_s1, data_s2;
    logic          fe;
    logic          wd_expired;

    // Idle bus is high on both lines, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge CLK_G or negedge reset_G) begin
        if (!reset_G) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2data_in;
            data_s2  <= data_s1;
        end
    end

    assign fe         = clk_prev & ~clk_s2;
    assign wd_expired = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK_G or negedge reset_G) begin
        if (!reset_G) begin
            state           <= S_IDLE;
            frame           <= '0;
            bit_idx         <= '0;
            inh_cnt         <= '0;
            wd_cnt          <= '0;
            tx_busy         <= 1'b0;
            tx_done         <= 1'b0;
            tx_ack_ok       <= 1'b0;
            tx_err          <= 1'b0;
            ps2clk_drv_low  <= 1'b0;
            ps2data_drv_low <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        frame          <= {1'b1, ~^tx_data, tx_data};
                        inh_cnt        <= '0;
                        tx_busy        <= 1'b1;
                        tx_ack_ok      <= 1'b0;
                        ps2clk_drv_low <= 1'b1;
                        state          <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        ps2data_drv_low <= 1'b1;
                        state           <= S_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    ps2clk_drv_low <= 1'b0;
                    bit_idx        <= '0;
                    wd_cnt         <= '0;
                    state          <= S_BITS;
                end
                default: begin
                    // A return to idle bus in WAIT wins over the watchdog; elsewhere an edge does.
                    if (state == S_WAIT && clk_s2 && data_s2) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= S_IDLE;
                    end else if (fe) begin
                        wd_cnt <= '0;
                        if (state == S_BITS) begin
                            ps2data_drv_low <= ~frame[bit_idx];
                            if (bit_idx == 4'd9) begin
                                state <= S_ACK;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else if (state == S_ACK) begin
                            tx_ack_ok <= ~data_s2;
                            state     <= S_WAIT;
                        end
                    end else if (wd_expired) begin
                        ps2clk_drv_low  <= 1'b0;
                        ps2data_drv_low <= 1'b0;
                        tx_err          <= 1'b1;
                        tx_busy         <= 1'b0;
                        state           <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with an open-drain PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;
    logic       CLK_G;
    logic       reset_G;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, tx_ack_ok, tx_err;
    logic       ps2clk_drv_low, ps2data_drv_low;
    logic       dev_clk_low, dev_data_low;
    logic       ps2clk, ps2data;
    int         checks;
    int         errors;

    assign ps2clk  = !(ps2clk_drv_low || dev_clk_low);
    assign ps2data = !(ps2data_drv_low || dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(500)) dut (
        .CLK_G(CLK_G), .reset_G(reset_G), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_ack_ok(tx_ack_ok), .tx_err(tx_err),
        .ps2clk_in(ps2clk), .ps2data_in(ps2data),
        .ps2clk_drv_low(ps2clk_drv_low), .ps2data_drv_low(ps2data_drv_low)
    );

    initial CLK_G = 1'b0;
    always #0.5 CLK_G = ~CLK_G;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_and_request(input logic [7:0] b);
        int cnt;
        @(negedge CLK_G);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge CLK_G);
        tx_start = 1'b0;
        check("busy_after_accept", tx_busy, 1);
        check("clk_low_after_accept", ps2clk_drv_low, 1);
        cnt = 0;
        while (ps2clk_drv_low && !ps2data_drv_low && cnt < 100) begin
            cnt++;
            @(negedge CLK_G);
        end
        check("inhibit_cycles", cnt, 20);
        check("req_both_low", {ps2clk_drv_low, ps2data_drv_low}, 2'b11);
        @(negedge CLK_G);
        check("req_clk_released", {ps2clk_drv_low, ps2data_drv_low}, 2'b01);
    endtask

    task automatic dev_clock(input int n, input bit ack, output logic [9:0] samp);
        int t;
        t    = 0;
        samp = '0;
        while (!(ps2clk === 1'b1 && ps2data === 1'b0) && t < 200) begin
            @(negedge CLK_G);
            t++;
        end
        check("dev_sees_request", t < 200, 1);
        for (int e = 1; e <= n; e++) begin
            #10;
            dev_clk_low = 1'b1;
            if (e == 11 && ack) dev_data_low = 1'b1;
            #10;
            dev_clk_low = 1'b0;
            if (e <= 10) samp[e-1] = ps2data;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic expect_done(input string tag, input logic exp_ack);
        int   dones, errs;
        logic ack_seen, busy_seen;
        dones = 0; errs = 0; ack_seen = 1'bx; busy_seen = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK_G);
            if (tx_done) begin
                dones++;
                ack_seen  = tx_ack_ok;
                busy_seen = tx_busy;
            end
            if (tx_err) errs++;
        end
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_err_count"}, errs, 0);
        check({tag, "_ack_ok"}, ack_seen, exp_ack);
        check({tag, "_busy_at_done"}, busy_seen, 0);
        check({tag, "_ack_held"}, tx_ack_ok, exp_ack);
    endtask

    task automatic send(input string tag, input logic [7:0] b, input logic [9:0] exp_frame, input bit ack);
        logic [9:0] samp;
        start_and_request(b);
        dev_clock(11, ack, samp);
        check({tag, "_frame"}, samp, exp_frame);
        expect_done(tag, ack);
    endtask

    logic [9:0] samp_main;
    int         cyc;

    initial begin
        checks = 0; errors = 0;
        tx_data = 8'h00; tx_start = 1'b0;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        reset_G = 1'b0;
        repeat (3) @(negedge CLK_G);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_ack_ok", tx_ack_ok, 0);
        check("rst_err", tx_err, 0);
        check("rst_drives", {ps2clk_drv_low, ps2data_drv_low}, 2'b00);
        reset_G = 1'b1;
        repeat (3) @(negedge CLK_G);

        // frames are {stop, odd parity, data}, data[0] sent first
        send("ed", 8'hED, 10'h3ED, 1'b1);
        send("x01", 8'h01, 10'h201, 1'b1);
        send("x00", 8'h00, 10'h300, 1'b1);
        send("ff_noack", 8'hFF, 10'h3FF, 1'b0);

        // device stops clocking after 4 edges
        start_and_request(8'hED);
        dev_clock(4, 1'b0, samp_main);
        cyc = 0;
        while (!tx_err && cyc < 700) begin
            @(negedge CLK_G);
            cyc++;
        end
        check("to_err_seen", tx_err, 1);
        check("to_latency_window", (cyc >= 480 && cyc <= 510), 1);
        check("to_drives", {ps2clk_drv_low, ps2data_drv_low}, 2'b00);
        check("to_busy", tx_busy, 0);
        check("to_no_done", tx_done, 0);
        repeat (5) @(negedge CLK_G);
        send("after_to", 8'hED, 10'h3ED, 1'b1);

        // asynchronous reset in the middle of the data bits
        start_and_request(8'hED);
        dev_clock(2, 1'b0, samp_main);
        repeat (3) @(negedge CLK_G);
        check("mid_data_driven", ps2data_drv_low, 1);
        #0.2;
        reset_G = 1'b0;
        #0.1;
        check("async_rst_drives", {ps2clk_drv_low, ps2data_drv_low}, 2'b00);
        check("async_rst_busy", tx_busy, 0);
        repeat (3) @(negedge CLK_G);
        reset_G = 1'b1;
        repeat (3) @(negedge CLK_G);
        send("after_rst", 8'hED, 10'h3ED, 1'b1);

        // start while busy must not disturb the frame in flight
        start_and_request(8'hED);
        fork
            dev_clock(11, 1'b1, samp_main);
            begin
                repeat (30) @(negedge CLK_G);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge CLK_G);
                tx_start = 1'b0;
            end
        join
        check("busy_start_frame", samp_main, 10'h3ED);
        expect_done("busy_start", 1'b1);
        check("busy_start_no_restart", {tx_busy, ps2clk_drv_low}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #90000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, for example 0xED (set LEDs) or 0xFF (reset), to the keyboard over the same two open-drain lines the keyboard receiver uses. It requests the bus, shifts out the data bits, parity and stop bit on device-generated clock edges, checks the device ACK, and reports done or error. It sits beside the receiver in `Proyect`; while `tx_busy` is high, the receiver ignores the bus.

## Interface
- `INHIBIT_CYCLES`, default 10000: `CLK_G` cycles that the clock line is held low before the request (100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 1500000: maximum `CLK_G` cycles between device clock falling edges before abort (15 ms).
- `CLK_G` input, 1 bit: system clock. Everything is in this single domain.
- `reset_G` input, 1 bit: asynchronous, active-low reset.
- `tx_data` input, 8 bits: byte to send. Sampled only on an accepted start.
- `tx_start` input, 1 bit: 1-cycle request. Accepted only in IDLE.
- `tx_busy` output, 1 bit: high from the cycle after accept until the cycle of `tx_done` or `tx_err`.
- `tx_done` output, 1 bit: 1-cycle pulse when the transfer ends normally.
- `tx_ack_ok` output, 1 bit: ACK result, valid in the cycle `tx_done` pulses. Holds its value until the next accept.
- `tx_err` output, 1 bit: 1-cycle pulse on timeout.
- `ps2clk_in` input, 1 bit: raw PS/2 clock line (asynchronous).
- `ps2data_in` input, 1 bit: raw PS/2 data line (asynchronous).
- `ps2clk_drv_low` output, 1 bit: 1 pulls the clock line low; 0 releases it (high-Z).
- `ps2data_drv_low` output, 1 bit: 1 pulls the data line low; 0 releases it (high-Z).

## Operation
- Both line inputs pass through 2-flop synchronizers. A falling edge `fe` is flagged when the previous synced clock is 1 and the current synced clock is 0.
- On accept, latch `tx_data` and compute parity = ~^`tx_data` (odd parity). Build a 10-bit frame: `data[0]` first through `data[7]`, then parity, then stop = 1.
- IDLE:
  - All outputs 0, lines released.
  - `fe` is ignored.
  - `tx_start` latches the frame and goes to INHIBIT.
- INHIBIT:
  - `ps2clk_drv_low`=1.
  - A counter runs `INHIBIT_CYCLES`; on expiry go to REQ.
- REQ:
  - `ps2clk_drv_low`=1 and `ps2data_drv_low`=1 for exactly 1 cycle (start bit = 0), then release the clock and go to BITS.
  - Data stays driven low.
- BITS:
  - On each `fe`, drive frame bit k (k = 0..9): `ps2data_drv_low` = ~bit.
  - Stop bit, k = 9, releases data.
  - After k = 9 has been driven, go to ACK.
- ACK:
  - On the next `fe`, sample synced data: `tx_ack_ok` = ~data (0 on the line means ACK).
  - Then go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synced clock = 1 and synced data = 1.
  - Pulse `tx_done`, return to IDLE.
  - A missing ACK (`tx_ack_ok`=0) is still reported through `tx_done`, not `tx_err`.
- Timeout:
  - In BITS, ACK and WAIT_IDLE, a watchdog counts cycles and is cleared on entry and on every `fe`.
  - Reaching `TIMEOUT_CYCLES` releases both lines, pulses `tx_err` with `tx_done`=0, and goes to IDLE.
- `tx_start` while busy is ignored; the latched frame does not change.
- Reset, any time including mid-frame: both drives go to 0 immediately (asynchronous), all state returns to IDLE, counters clear, `tx_ack_ok`=0.

## Timing
- Reset values: `tx_busy`=0, `tx_done`=0, `tx_ack_ok`=0, `tx_err`=0, `ps2clk_drv_low`=0, `ps2data_drv_low`=0.
- Accept at edge N: at N+1, `tx_busy`=1 and `ps2clk_drv_low`=1.
- Clock held low for exactly `INHIBIT_CYCLES` cycles; then 1 cycle with both lines low; then clock released, data still low.
- Data changes 1 cycle after `fe` is detected, which is 3 `CLK_G` edges after the raw falling edge, given the synchronizer. This is well inside the device's clock-low half period.
- `tx_done` fires 1 cycle after both synced lines read 1. Minimum frame = 11 device falling edges.
- `tx_done` and `tx_err` are mutually exclusive and never assert in the same cycle as `tx_start` acceptance.

## Test plan
All scenarios use `INHIBIT_CYCLES`=20 and `TIMEOUT_CYCLES`=500. The bench device model waits for the clock line to be released with data low, then toggles its clock with a 10 ns half period. It samples data on rising edges, pulls data low on the 11th falling edge, then releases.

- Send 0xED, device ACKs:
  - Expected sampled bits: 1,0,1,1,0,1,1,1; parity 1; stop 1.
  - `tx_done` pulses once with `tx_ack_ok`=1.
  - Clock held low for exactly 20 cycles.
- Send 0x01, device ACKs: sampled parity = 0. Send 0x00: parity = 1. Both end with `tx_ack_ok`=1.
- Send 0xFF, device omits the ACK (data stays high on edge 11): `tx_done` pulses with `tx_ack_ok`=0, `tx_err`=0.
- Device stops clocking after 4 edges: 500 cycles later `tx_err` pulses, both drives are 0, `tx_busy` drops. A following 0xED transfer completes normally.
- Assert `reset_G`=0 mid-BITS: both drives drop to 0 in the same cycle without waiting for a clock edge, `tx_busy`=0. After release, a new send of 0xED succeeds.
- Pulse `tx_start` with 0x55 while busy sending 0xED: the device still receives 0xED; only one `tx_done` occurs.
